flow_arbiter: RTL

- Scheduling stage directly upstream of the 4x4 routing mux. It drives the mux source select `demux0` and the destination select `dest`.
- Watches four input FIFOs (fifo0..3, show-ahead) and four output FIFOs (fifo4..7).
- Picks one non-empty source per cycle by round-robin, reads the destination from bits [9:8] of that source's head word, and issues the matching pop and push.
- Skips any source whose target output FIFO is almost full.

---
 rtl/flow_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/flow_arbiter.sv
// Round-robin scheduler in front of the 4x4 routing mux: picks one non-empty input FIFO per
// cycle, skips sources whose target output FIFO is almost full, and drives registered pop/push/select.
module flow_arbiter #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo0_out,
  input  logic [DATA_W-1:0] fifo1_out,
  input  logic [DATA_W-1:0] fifo2_out,
  input  logic [DATA_W-1:0] fifo3_out,
  input  logic              fifo0_empty,
  input  logic              fifo1_empty,
  input  logic              fifo2_empty,
  input  logic              fifo3_empty,
  input  logic              fifo4_afull,
  input  logic              fifo5_afull,
  input  logic              fifo6_afull,
  input  logic              fifo7_afull,
  output logic [1:0]        demux0,
  output logic [1:0]        dest,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic              push4,
  output logic              push5,
  output logic              push6,
  output logic              push7,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  tx_count
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACTIVE = 2'b01;
  localparam logic [1:0] ST_STALL  = 2'b10;

  logic [1:0]       r_demux;
  logic [1:0]       r_dest;
  logic [3:0]       r_pop;
  logic [3:0]       r_push;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_tx;
  logic [1:0]       r_rr;
  logic [1:0]       r_lg;
  logic             r_lg_valid;

  logic [DATA_W-1:0] w_head [4];
  logic [1:0]        w_dst  [4];
  logic [3:0]        w_empty;
  logic [3:0]        w_afull;
  logic [3:0]        w_elig;
  logic [3:0]        w_af_block;
  logic              w_grant;
  logic [1:0]        w_win;
  logic [1:0]        w_win_dst;
  logic [1:0]        w_cand;
  logic [1:0]        w_state_next;

  assign w_head[0] = fifo0_out;
  assign w_head[1] = fifo1_out;
  assign w_head[2] = fifo2_out;
  assign w_head[3] = fifo3_out;
  assign w_empty   = {fifo3_empty, fifo2_empty, fifo1_empty, fifo0_empty};
  assign w_afull   = {fifo7_afull, fifo6_afull, fifo5_afull, fifo4_afull};

  // A source granted last cycle is excluded: its empty flag does not yet reflect that pop.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_src
      logic w_excl;
      assign w_dst[gi]      = w_head[gi][DATA_W-1:DATA_W-2];
      assign w_excl         = r_lg_valid && (r_lg == 2'(gi));
      assign w_elig[gi]     = !w_empty[gi] && !w_excl && !w_afull[w_dst[gi]];
      assign w_af_block[gi] = !w_empty[gi] && !w_excl &&  w_afull[w_dst[gi]];
    end
  endgenerate

  // Next-state: search rr_ptr+1 .. rr_ptr+4 (the last wraps back to rr_ptr itself).
  always_comb begin
    w_grant   = 1'b0;
    w_win     = r_rr;
    w_cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_rr + 2'(k);
      if (!w_grant && w_elig[w_cand]) begin
        w_grant = 1'b1;
        w_win   = w_cand;
      end
    end
    w_win_dst = w_dst[w_win];
    if (w_grant)
      w_state_next = ST_ACTIVE;
    else if (|w_af_block)
      w_state_next = ST_STALL;
    else
      w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_demux    <= '0;
      r_dest     <= '0;
      r_pop      <= '0;
      r_push     <= '0;
      r_state    <= ST_IDLE;
      r_tx       <= '0;
      r_rr       <= 2'd3;
      r_lg       <= '0;
      r_lg_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_demux    <= w_win;
        r_dest     <= w_win_dst;
        r_pop      <= 4'b0001 << w_win;
        r_push     <= 4'b0001 << w_win_dst;
        r_rr       <= w_win;
        r_lg       <= w_win;
        r_lg_valid <= 1'b1;
        r_tx       <= r_tx + CNT_W'(1);
      end else begin
        r_pop      <= '0;
        r_push     <= '0;
        r_lg_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    demux0   = r_demux;
    dest     = r_dest;
    pop0     = r_pop[0];
    pop1     = r_pop[1];
    pop2     = r_pop[2];
    pop3     = r_pop[3];
    push4    = r_push[0];
    push5    = r_push[1];
    push6    = r_push[2];
    push7    = r_push[3];
    state    = r_state;
    tx_count = r_tx;
  end

endmodule
